// File: rtl/sequence_detector.sv
// Serial detector for the 6-bit word 010011, sent MSB first, with a match counter and a periodicity lock.
// Latency: detect, det_cnt, locked and state_dbg are all registered. They update one clk after the edge that samples the bit.
// Backpressure: none. en qualifies each din bit, and cycles with en=0 freeze the detector (detect=0).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   en         in   bit-valid for din
//   din        in   serial data bit
//   cnt_clr    in   synchronous clear of det_cnt (wins over a same-cycle match)
//   detect     out  one-cycle pulse per completed match
//   det_cnt    out  saturating 8-bit match count
//   locked     out  stream aligned to a 6-bit periodic repetition of the word
//   state_dbg  out  current FSM state code (0..5)
module sequence_detector (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       din,
   input  logic       cnt_clr,
   output logic       detect,
   output logic [7:0] det_cnt,
   output logic       locked,
   output logic [2:0] state_dbg
);

   // Each state is named after the longest prefix of 010011 matched so far.
   typedef enum logic [2:0] {
      IDLE = 3'd0,   // no prefix
      P1   = 3'd1,   // "0"
      P2   = 3'd2,   // "01"
      P3   = 3'd3,   // "010"
      P4   = 3'd4,   // "0100"
      P5   = 3'd5    // "01001"
   } state_t;

   state_t     r_state;
   logic       r_detect;
   logic [7:0] r_det_cnt;
   logic       r_locked;
   logic [2:0] r_gap;     // non-matching en bits since the last match, saturates at 7
   logic [1:0] r_run;     // consecutive periodic matches, saturates at 3

   state_t     w_next;
   logic       w_match;
   logic       w_gap_hit;
   logic [1:0] w_run_inc;

   // A match completes only from P5 on a 1. The caller qualifies it with en.
   assign w_match   = (r_state == P5) && din;

   // gap==5 means the current bit is exactly 6 bits after the previous match.
   // This is where the next periodic match is due.
   assign w_gap_hit = (r_gap == 3'd5);
   assign w_run_inc = (r_run == 2'd3) ? 2'd3 : r_run + 2'd1;

   // Next-state table. The fallbacks follow the longest suffix that is still
   // a prefix of the word. For example, "010010" resumes at "010".
   // The unused codes 6 and 7 fall back to IDLE.
   always_comb begin
      w_next = IDLE;
      case (r_state)
         IDLE:    w_next = din ? IDLE : P1;
         P1:      w_next = din ? P2   : P1;
         P2:      w_next = din ? IDLE : P3;
         P3:      w_next = din ? P2   : P4;
         P4:      w_next = din ? P5   : P1;
         P5:      w_next = din ? IDLE : P3;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_detect  <= 1'b0;
         r_det_cnt <= 8'd0;
         r_locked  <= 1'b0;
         r_gap     <= 3'd7;
         r_run     <= 2'd0;
      end else begin
         r_detect <= 1'b0;

         if (en) begin
            r_state  <= w_next;
            r_detect <= w_match;

            if (w_match) begin
               r_gap <= 3'd0;
               if (w_gap_hit) begin
                  // Periodic match. The match that takes run to 2 is the
                  // third in a row at 6-bit spacing, so it sets locked.
                  r_run <= w_run_inc;
                  if (w_run_inc >= 2'd2) begin
                     r_locked <= 1'b1;
                  end
               end else begin
                  r_run <= 2'd0;
               end
            end else begin
               if (r_gap != 3'd7) begin
                  r_gap <= r_gap + 3'd1;
               end
               // An expected periodic match was missed, so alignment is lost.
               if (w_gap_hit) begin
                  r_run    <= 2'd0;
                  r_locked <= 1'b0;
               end
            end
         end

         // The clear has priority over a coincident match.
         if (cnt_clr) begin
            r_det_cnt <= 8'd0;
         end else if (en && w_match && (r_det_cnt != 8'hFF)) begin
            r_det_cnt <= r_det_cnt + 8'd1;
         end
      end
   end

   assign detect    = r_detect;
   assign det_cnt   = r_det_cnt;
   assign locked    = r_locked;
   assign state_dbg = r_state;

endmodule
